// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences the PC, reads the 16-entry program memory and hands opcodes to the decoder.
// Optional FETCH_PREFETCH_EN adds a 2-entry opcode FIFO for one-opcode-per-cycle fetch.
module instr_fetch #(
  parameter int                ADDR_W      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        opcode,
  output logic              opcode_valid,
  input  logic              opcode_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted,
  input  logic              resume
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r;
  logic              halted_r;

`ifdef FETCH_PREFETCH_EN
  logic [7:0]        fifo_op_r [2];
  logic [ADDR_W-1:0] fifo_pc_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic              pop_s;
  logic              push_s;
  logic              halt_pop_s;
  logic [1:0]        occ_s;
  logic              issue_s;

  assign pop_s      = (count_r != 2'd0) & opcode_ready;
  assign push_s     = inflight_r;
  assign halt_pop_s = pop_s & (fifo_op_r[rd_ptr_r] == HALT_OPCODE);
  // Occupancy counts the slot freed by this cycle's pop so a full pipeline keeps streaming.
  assign occ_s      = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
  assign issue_s    = ~halted_r & ~jump_en & ~halt_pop_s & (occ_s < 2'd2);

  // FIFO, in-flight read tracking, PC and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_op_r[i] <= 8'h00;
        fifo_pc_r[i] <= RESET_PC;
      end
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
      pc_r          <= RESET_PC;
      halted_r      <= 1'b0;
    end else if (jump_en) begin
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
      pc_r       <= jump_addr;
      halted_r   <= 1'b0;
    end else if (halt_pop_s) begin
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
      pc_r       <= fifo_pc_r[rd_ptr_r] + PC_ONE;
      halted_r   <= 1'b1;
    end else begin
      if (halted_r && resume) begin
        halted_r <= 1'b0;
      end
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r          <= pc_r + PC_ONE;
        inflight_pc_r <= pc_r;
      end
      if (push_s) begin
        fifo_op_r[wr_ptr_r] <= mem_rdata;
        fifo_pc_r[wr_ptr_r] <= inflight_pc_r;
        wr_ptr_r            <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  assign mem_rd       = ~rst & issue_s;
  assign mem_addr     = pc_r;
  assign opcode       = fifo_op_r[rd_ptr_r];
  assign pc_out       = fifo_pc_r[rd_ptr_r];
  assign opcode_valid = (count_r != 2'd0);
  assign halted       = halted_r;

`else
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        opcode_r;
  logic [ADDR_W-1:0] pc_out_r;
  logic              opcode_valid_r;
  logic              transfer_s;

  assign transfer_s = opcode_valid_r & opcode_ready;

  // Next-state logic; a jump overrides every state.
  always_comb begin
    state_s = state_r;
    if (jump_en) begin
      state_s = REQ;
    end else begin
      case (state_r)
        REQ:  state_s = WAIT;
        WAIT: state_s = HOLD;
        HOLD: begin
          if (transfer_s) begin
            state_s = (opcode_r == HALT_OPCODE) ? HALT : REQ;
          end else begin
            state_s = HOLD;
          end
        end
        HALT: begin
          if (resume) begin
            state_s = REQ;
          end else begin
            state_s = HALT;
          end
        end
        default: state_s = REQ;
      endcase
    end
  end

  // State register and datapath; the WAIT capture is skipped on a jump, discarding the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= REQ;
      pc_r           <= RESET_PC;
      opcode_r       <= 8'h00;
      pc_out_r       <= RESET_PC;
      opcode_valid_r <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (jump_en) begin
        pc_r           <= jump_addr;
        opcode_valid_r <= 1'b0;
        halted_r       <= 1'b0;
      end else begin
        case (state_r)
          WAIT: begin
            opcode_r       <= mem_rdata;
            pc_out_r       <= pc_r;
            opcode_valid_r <= 1'b1;
            pc_r           <= pc_r + PC_ONE;
          end
          HOLD: begin
            if (transfer_s) begin
              opcode_valid_r <= 1'b0;
              halted_r       <= (opcode_r == HALT_OPCODE);
            end
          end
          HALT: begin
            if (resume) begin
              halted_r <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_rd       = ~rst & (state_r == REQ);
  assign mem_addr     = pc_r;
  assign opcode       = opcode_r;
  assign pc_out       = pc_out_r;
  assign opcode_valid = opcode_valid_r;
  assign halted       = halted_r;
`endif

endmodule
